// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MEM stage, the external loader/debug port and Data_Mem.
// The arbiter takes the slave view; whatever drives requests and models the memory takes the master view.
interface dmem_arbiter_if;
    logic        cpu_mem_read;
    logic        cpu_mem_write;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_stall;

    logic        ext_req;
    logic        ext_we;
    logic        ext_lock;
    logic [15:0] ext_addr;
    logic [15:0] ext_wdata;
    logic        ext_gnt;
    logic [15:0] ext_rdata;

    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    modport slave (
        input  cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
        output ext_gnt, ext_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
        input  ext_gnt, ext_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU has default priority, EXT gets starvation
// protection and bounded locked bursts, and the pipeline is stalled while EXT owns the memory.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_BURST    = 8
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);

    localparam int WAIT_W  = $clog2(STARVE_LIMIT + 1);
    localparam int BURST_W = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;

    localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(STARVE_LIMIT);
    localparam logic [WAIT_W-1:0]  WAIT_ONE   = WAIT_W'(1);
    localparam logic [BURST_W-1:0] BURST_ONE  = BURST_W'(1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EXT_BURST = 2'd1,
        CPU_PRIO  = 2'd2
    } state_t;

    state_t             state_r;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic [BURST_W-1:0] burst_cnt_r;

    logic        cpu_req_s;
    logic        ext_gnt_s;
    logic        mem_read_s;
    logic        mem_write_s;
    logic [15:0] mem_addr_s;
    logic [15:0] mem_wdata_s;

    assign cpu_req_s = bus.cpu_mem_read | bus.cpu_mem_write;

    // Grant decision from registered state and the current requests.
    always_comb begin
        ext_gnt_s = 1'b0;
        if (rst) begin
            ext_gnt_s = 1'b0;
        end else begin
            case (state_r)
                IDLE:      ext_gnt_s = bus.ext_req & (~cpu_req_s | (wait_cnt_r == WAIT_MAX));
                EXT_BURST: ext_gnt_s = bus.ext_req;
                CPU_PRIO:  ext_gnt_s = 1'b0;
                default:   ext_gnt_s = 1'b0;
            endcase
        end
    end

    // Memory port mux; a CPU access that loses arbitration is simply not forwarded.
    always_comb begin
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        mem_addr_s  = bus.cpu_addr;
        mem_wdata_s = bus.cpu_wdata;
        if (rst) begin
            mem_read_s  = 1'b0;
            mem_write_s = 1'b0;
            mem_addr_s  = bus.cpu_addr;
            mem_wdata_s = bus.cpu_wdata;
        end else if (ext_gnt_s) begin
            mem_read_s  = ~bus.ext_we;
            mem_write_s = bus.ext_we;
            mem_addr_s  = bus.ext_addr;
            mem_wdata_s = bus.ext_wdata;
        end else begin
            mem_read_s  = bus.cpu_mem_read;
            mem_write_s = bus.cpu_mem_write;
            mem_addr_s  = bus.cpu_addr;
            mem_wdata_s = bus.cpu_wdata;
        end
    end

    assign bus.ext_gnt   = ext_gnt_s;
    assign bus.cpu_stall = cpu_req_s & ext_gnt_s;
    assign bus.mem_read  = mem_read_s;
    assign bus.mem_write = mem_write_s;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_wdata = mem_wdata_s;
    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.ext_rdata = bus.mem_rdata;

    // Arbitration FSM with starvation counter and burst beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            wait_cnt_r  <= '0;
            burst_cnt_r <= '0;
        end else begin
            // The post-burst CPU slot must not erase or advance EXT's waiting history.
            if (state_r == CPU_PRIO) begin
                wait_cnt_r <= wait_cnt_r;
            end else if (ext_gnt_s || !bus.ext_req) begin
                wait_cnt_r <= '0;
            end else if (wait_cnt_r != WAIT_MAX) begin
                wait_cnt_r <= wait_cnt_r + WAIT_ONE;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end

            case (state_r)
                IDLE: begin
                    if (ext_gnt_s && bus.ext_lock) begin
                        if (MAX_BURST <= 1) begin
                            state_r     <= CPU_PRIO;
                            burst_cnt_r <= '0;
                        end else begin
                            state_r     <= EXT_BURST;
                            burst_cnt_r <= BURST_ONE;
                        end
                    end else begin
                        state_r     <= IDLE;
                        burst_cnt_r <= '0;
                    end
                end
                EXT_BURST: begin
                    // A forced end wins over a simultaneous lock release so the CPU always gets its slot.
                    if (ext_gnt_s && (burst_cnt_r == BURST_LAST)) begin
                        state_r     <= CPU_PRIO;
                        burst_cnt_r <= '0;
                    end else if (!bus.ext_lock) begin
                        state_r     <= IDLE;
                        burst_cnt_r <= '0;
                    end else if (ext_gnt_s) begin
                        state_r     <= EXT_BURST;
                        burst_cnt_r <= burst_cnt_r + BURST_ONE;
                    end else begin
                        state_r     <= EXT_BURST;
                        burst_cnt_r <= burst_cnt_r;
                    end
                end
                CPU_PRIO: begin
                    state_r     <= IDLE;
                    burst_cnt_r <= '0;
                end
                default: begin
                    state_r     <= IDLE;
                    burst_cnt_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural Data_Mem model.
module tb_dmem_arbiter;

    logic clk;
    logic rst;
    logic mem_init;
    int   vectors;
    int   miscompares;

    logic [15:0] mem [0:255];

    dmem_arbiter_if bus ();

    dmem_arbiter #(.STARVE_LIMIT(4), .MAX_BURST(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data_Mem model: combinational read, write on the rising edge, preloaded to 0x1000+addr.
    assign bus.mem_rdata = mem[bus.mem_addr[7:0]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h1000 + 16'(i);
        end else if (bus.mem_write) begin
            mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        mem_init    = 1'b1;
        bus.cpu_mem_read  = 1'b0;
        bus.cpu_mem_write = 1'b0;
        bus.cpu_addr      = 16'h1234;
        bus.cpu_wdata     = 16'h5678;
        bus.ext_req       = 1'b1;
        bus.ext_we        = 1'b1;
        bus.ext_lock      = 1'b1;
        bus.ext_addr      = 16'h0099;
        bus.ext_wdata     = 16'h0000;
        step();
        step();
        mem_init = 1'b0;
        // Reset: everything suppressed, address passes from CPU.
        #1;
        check("rst_gnt",   16'(bus.ext_gnt),   16'd0);
        check("rst_stall", 16'(bus.cpu_stall), 16'd0);
        check("rst_mwr",   16'(bus.mem_write), 16'd0);
        check("rst_addr",  bus.mem_addr,       16'h1234);
        check("rst_wdata", bus.mem_wdata,      16'h5678);
        check("rst_state", 16'(dut.state_r),   16'd0);
        check("rst_wait",  16'(dut.wait_cnt_r), 16'd0);

        // Plain CPU load.
        rst = 1'b0;
        bus.ext_req = 1'b0; bus.ext_lock = 1'b0;
        bus.cpu_mem_read = 1'b1; bus.cpu_addr = 16'h0010;
        #1;
        check("cpu_rd",    16'(bus.mem_read),  16'd1);
        check("cpu_addr",  bus.mem_addr,       16'h0010);
        check("cpu_stall", 16'(bus.cpu_stall), 16'd0);
        check("cpu_gnt",   16'(bus.ext_gnt),   16'd0);
        check("cpu_rdata", bus.cpu_rdata,      16'h1010);
        step();

        // EXT write with no CPU access, then CPU reads it back.
        bus.cpu_mem_read = 1'b0;
        bus.ext_req = 1'b1; bus.ext_we = 1'b1; bus.ext_addr = 16'h0020; bus.ext_wdata = 16'hBEEF;
        #1;
        check("ew_gnt",   16'(bus.ext_gnt),   16'd1);
        check("ew_mwr",   16'(bus.mem_write), 16'd1);
        check("ew_mrd",   16'(bus.mem_read),  16'd0);
        check("ew_addr",  bus.mem_addr,       16'h0020);
        check("ew_wdata", bus.mem_wdata,      16'hBEEF);
        step();
        bus.ext_req = 1'b0;
        bus.cpu_mem_read = 1'b1; bus.cpu_addr = 16'h0020;
        #1;
        check("rb_beef", bus.cpu_rdata, 16'hBEEF);
        step();

        // Starvation: four denials, then EXT wins on the fifth cycle.
        bus.cpu_addr = 16'h0030;
        bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 16'h0021;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("sv_gnt",   16'(bus.ext_gnt),   16'd0);
            check("sv_addr",  bus.mem_addr,       16'h0030);
            check("sv_stall", 16'(bus.cpu_stall), 16'd0);
            step();
            check("sv_wait",  16'(dut.wait_cnt_r), 16'(i + 1));
        end
        #1;
        check("sv5_gnt",   16'(bus.ext_gnt),   16'd1);
        check("sv5_stall", 16'(bus.cpu_stall), 16'd1);
        check("sv5_addr",  bus.mem_addr,       16'h0021);
        check("sv5_rdata", bus.ext_rdata,      16'h1021);
        step();
        check("sv5_wait",  16'(dut.wait_cnt_r), 16'd0);
        bus.ext_req = 1'b0;
        step();

        // Locked EXT reads against a busy CPU: 4 denials, 8 beats, CPU_PRIO, 4 denials, starvation grant.
        bus.ext_req = 1'b1; bus.ext_lock = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 16'h0022;
        for (int c = 0; c < 18; c++) begin
            logic exp_gnt;
            exp_gnt = ((c >= 4) && (c < 12)) || (c == 17);
            #1;
            check("lb_gnt",   16'(bus.ext_gnt),   16'(exp_gnt));
            check("lb_stall", 16'(bus.cpu_stall), 16'(exp_gnt));
            if (c == 12) check("lb_prio", 16'(dut.state_r), 16'd2);
            step();
        end
        bus.ext_req = 1'b0; bus.ext_lock = 1'b0; bus.cpu_mem_read = 1'b0;
        step();
        check("lb_idle", 16'(dut.state_r), 16'd0);

        // Locked write burst, lock dropped on beat 3 while a CPU store waits.
        bus.ext_req = 1'b1; bus.ext_lock = 1'b1; bus.ext_we = 1'b1;
        for (int b = 0; b < 2; b++) begin
            bus.ext_addr = 16'h0040 + 16'(b); bus.ext_wdata = 16'hA000 + 16'(b);
            #1;
            check("ld_gnt", 16'(bus.ext_gnt), 16'd1);
            step();
        end
        bus.ext_addr = 16'h0042; bus.ext_wdata = 16'hA002; bus.ext_lock = 1'b0;
        bus.cpu_mem_write = 1'b1; bus.cpu_addr = 16'h0050; bus.cpu_wdata = 16'h5555;
        #1;
        check("ld3_gnt",   16'(bus.ext_gnt),   16'd1);
        check("ld3_stall", 16'(bus.cpu_stall), 16'd1);
        check("ld3_addr",  bus.mem_addr,       16'h0042);
        check("ld3_wdata", bus.mem_wdata,      16'hA002);
        step();
        bus.ext_req = 1'b0;
        check("ld_idle", 16'(dut.state_r), 16'd0);
        #1;
        check("st_mwr",   16'(bus.mem_write), 16'd1);
        check("st_addr",  bus.mem_addr,       16'h0050);
        check("st_stall", 16'(bus.cpu_stall), 16'd0);
        step();
        bus.cpu_mem_write = 1'b0; bus.cpu_mem_read = 1'b1;
        #1;
        check("st_rb", bus.cpu_rdata, 16'h5555);
        bus.cpu_addr = 16'h0042;
        #1;
        check("ld_rb", bus.cpu_rdata, 16'hA002);
        bus.cpu_mem_read = 1'b0;
        step();

        // Reset during beat 5 of a locked write burst.
        bus.ext_req = 1'b1; bus.ext_lock = 1'b1; bus.ext_we = 1'b1;
        for (int b = 0; b < 4; b++) begin
            bus.ext_addr = 16'h0060 + 16'(b); bus.ext_wdata = 16'hC000 + 16'(b);
            #1;
            check("rb_gnt", 16'(bus.ext_gnt), 16'd1);
            step();
        end
        bus.ext_addr = 16'h0064; bus.ext_wdata = 16'hC004;
        bus.cpu_mem_read = 1'b1; bus.cpu_addr = 16'h0070;
        rst = 1'b1;
        #1;
        check("rm_mwr",  16'(bus.mem_write), 16'd0);
        check("rm_gnt",  16'(bus.ext_gnt),   16'd0);
        check("rm_mrd",  16'(bus.mem_read),  16'd0);
        check("rm_addr", bus.mem_addr,       16'h0070);
        step();
        rst = 1'b0; bus.ext_req = 1'b0; bus.ext_lock = 1'b0;
        #1;
        check("rm_state", 16'(dut.state_r),     16'd0);
        check("rm_burst", 16'(dut.burst_cnt_r), 16'd0);
        check("rm_pass",  16'(bus.mem_read),    16'd1);
        check("rm_paddr", bus.mem_addr,         16'h0070);
        check("rm_pstl",  16'(bus.cpu_stall),   16'd0);
        bus.cpu_addr = 16'h0064;
        #1;
        check("rm_nowr", bus.cpu_rdata, 16'h1064);
        bus.cpu_addr = 16'h0063;
        #1;
        check("rm_b4",   bus.cpu_rdata, 16'hC003);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the pipeline MEM stage (CPU) and an external loader/debug port (EXT).
- Sits between EX_MEM outputs and Data_Mem. Drives the memory control, address and write-data inputs, and returns read data to both requesters.
- CPU has default priority. EXT is protected from starvation and can lock the memory for bounded bursts.
- While EXT owns the memory, the block raises a stall to freeze the pipeline.

Parameters:
- STARVE_LIMIT, 4: consecutive denied EXT cycles after which EXT wins over a pending CPU access.
- MAX_BURST, 8: maximum granted beats in one locked EXT burst.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_mem_read  in  1  MEM-stage load request.
- cpu_mem_write  in  1  MEM-stage store request.
- cpu_addr  in  16  MEM-stage address (ALU result).
- cpu_wdata  in  16  MEM-stage store data.
- cpu_rdata  out  16  load data to MEM_WB (equals mem_rdata).
- cpu_stall  out  1  freeze PC, IF_ID, ID_EX, EX_MEM, MEM_WB this cycle.
- ext_req  in  1  EXT access request.
- ext_we  in  1  1 = write, 0 = read.
- ext_lock  in  1  request or continue a locked burst.
- ext_addr  in  16  EXT address.
- ext_wdata  in  16  EXT write data.
- ext_gnt  out  1  EXT beat performed this cycle.
- ext_rdata  out  16  EXT read data (equals mem_rdata).
- mem_read  out  1  to Data_Mem memRead.
- mem_write  out  1  to Data_Mem memWrite.
- mem_addr  out  16  to Data_Mem address.
- mem_wdata  out  16  to Data_Mem write_data.
- mem_rdata  in  16  from Data_Mem read_data; combinational read.

Behaviour:
- cpu_req = cpu_mem_read | cpu_mem_write.
- Grant decisions are combinational from the registered state and current inputs. State, wait_cnt and burst_cnt are registered.
- Registered state: state in {IDLE, EXT_BURST, CPU_PRIO}; wait_cnt (width clog2(STARVE_LIMIT+1)); burst_cnt (width clog2(MAX_BURST)).
- Reset (rst=1 at clk edge): state=IDLE, wait_cnt=0, burst_cnt=0.
- While rst=1: ext_gnt=0, cpu_stall=0, mem_read=0, mem_write=0, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
- Mux rules:
  - When ext_gnt=1: mem_read=~ext_we, mem_write=ext_we, addr/wdata come from EXT.
  - Otherwise memory signals pass through from CPU.
  - cpu_stall=1 exactly when cpu_req=1 and ext_gnt=1.
- IDLE:
  - EXT is granted when ext_req & (~cpu_req | wait_cnt==STARVE_LIMIT). Otherwise the CPU is granted.
  - If EXT is granted with ext_lock=1, next state is EXT_BURST and burst_cnt becomes 1. If EXT is granted without ext_lock, state stays IDLE.
- wait_cnt:
  - Increments, saturating at STARVE_LIMIT, when ext_req=1 and ext_gnt=0.
  - Clears to 0 when ext_gnt=1 or ext_req=0.
- EXT_BURST:
  - ext_gnt = ext_req, regardless of cpu_req.
  - burst_cnt increments on each granted beat.
  - Exit to IDLE when ext_lock=0 at a clock edge; that cycle's beat is still granted if ext_req=1.
  - Forced end: when a beat is granted with burst_cnt==MAX_BURST-1, next state is CPU_PRIO and burst_cnt=0.
  - Idle cycles (ext_req=0, ext_lock=1) keep ownership and stall a requesting CPU.
- CPU_PRIO:
  - Lasts one cycle; ext_gnt=0 unconditionally, wait_cnt held.
  - Next state IDLE. Prevents back-to-back burst lockout of the CPU.
- EXT handshake:
  - EXT holds req, we, addr and wdata stable until ext_gnt=1. One beat per granted cycle.
  - Read data is valid in the grant cycle.
  - A write commits at the clock edge ending the grant cycle.
- CPU handshake: while cpu_stall=1 the pipeline holds EX_MEM stable, so the CPU access re-presents next cycle.
- A stalled CPU store must never reach mem_write.
- Reset mid-burst: rst forces IDLE; the in-flight beat's outputs are suppressed that cycle.
- Simultaneous CPU and EXT request in IDLE with wait_cnt<STARVE_LIMIT: CPU wins, wait_cnt increments.

Test Plan:
- Reset, then cpu_mem_read=1, cpu_addr=0x0010, ext_req=0 → mem_read=1, mem_addr=0x0010, cpu_stall=0, ext_gnt=0.
- ext_req=1, ext_we=1, ext_addr=0x0020, ext_wdata=0xBEEF, no CPU access → ext_gnt=1 same cycle, mem_write=1. A later CPU read of 0x0020 returns 0xBEEF.
- CPU load every cycle with ext_req=1: ext_gnt=0 for 4 cycles, wait_cnt reaching 4. On the 5th cycle ext_gnt=1 and cpu_stall=1, then wait_cnt=0.
- ext_lock=1, ext_req=1 for 12 cycles with continuous CPU requests → 8 consecutive ext_gnt=1 with cpu_stall=1, then one CPU_PRIO cycle (ext_gnt=0, cpu_stall=0), then EXT re-granted only via the starvation rule.
- Locked burst, ext_lock dropped after beat 3 → beat 3 granted, state IDLE next cycle, a pending CPU store commits with no stall.
- rst asserted during beat 5 of a burst → that cycle mem_write=0, ext_gnt=0. Next cycle state=IDLE, CPU access passes through.
